// File: rtl/bus_cycle_seq.sv
// bus_cycle_seq: sm83 M-cycle bus sequencer (T1..T4, TW wait stretch).
// Ports: CLK/RESET; req_rd/req_wr/req_addr/wdata request side;
//   WAIT, Test1, DL bus inputs; A/RD/WR/DataOut/DV to the data mux;
//   rdata, ready, done, err to the decoder.
// Option: BUS_SEQ_PIPELINE_EN lets a request be accepted in T4.
module bus_cycle_seq #(
  parameter int          ADDR_W    = 16,
  parameter logic [7:0]  IDLE_DATA = 8'hFF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        wdata,
  input  logic              WAIT,
  input  logic              Test1,
  input  logic [7:0]        DL,
  output logic [ADDR_W-1:0] A,
  output logic              RD,
  output logic              WR,
  output logic              DataOut,
  output logic [7:0]        DV,
  output logic [7:0]        rdata,
  output logic              ready,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_TW,
    S_T3,
    S_T4
  } state_t;

  state_t              state_q, state_d;
  logic                op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          dv_q, dv_d;
  logic [7:0]          rdata_q, rdata_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                dout_q, dout_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                acc_ok, acc_bad;
  logic                strobe_st;

`ifdef BUS_SEQ_PIPELINE_EN
  assign ready = (state_q == S_IDLE) || (state_q == S_T4);
`else
  assign ready = (state_q == S_IDLE);
`endif

  assign acc_ok  = ready & (req_rd ^ req_wr);
  assign acc_bad = ready & req_rd & req_wr;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    dv_d    = dv_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_IDLE;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = WAIT ? S_TW : S_T3;
      S_TW:   state_d = WAIT ? S_TW : S_T3;
      S_T3: begin
        state_d = S_T4;
        // Bus disabled: the precharged value is what a read sees.
        if (!op_q)
          rdata_d = Test1 ? IDLE_DATA : DL;
      end
      S_T4:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (acc_ok) begin
      state_d = S_T1;
      addr_d  = req_addr;
      op_d    = req_wr;
      if (req_wr)
        dv_d = wdata;
    end else if (acc_bad) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end

    // Strobes are decoded from the next state so they flip on edges only.
    strobe_st = (state_d == S_T2) || (state_d == S_TW) ||
                (state_d == S_T3);
    rd_d   = !op_d && (strobe_st || (state_d == S_T1));
    wr_d   = op_d && strobe_st;
    dout_d = op_d && strobe_st;
    done_d = (state_d == S_T4);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      addr_q  <= '0;
      dv_q    <= '0;
      rdata_q <= IDLE_DATA;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      dout_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      dv_q    <= dv_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Test1 masks the strobes without touching sequencing.
  assign RD      = rd_q & ~Test1;
  assign WR      = wr_q & ~Test1;
  assign DataOut = dout_q;
  assign A       = addr_q;
  assign DV      = dv_q;
  assign rdata   = rdata_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bus_cycle_seq.sv
// tb_bus_cycle_seq: directed self-checking bench for bus_cycle_seq.
// Inputs change 1ns after the rising edge; outputs are read there too.
module tb_bus_cycle_seq;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        req_rd, req_wr;
  logic [15:0] req_addr;
  logic [7:0]  wdata;
  logic        WAIT, Test1;
  logic [7:0]  DL;
  logic [15:0] A;
  logic        RD, WR, DataOut;
  logic [7:0]  DV, rdata;
  logic        ready, done, err;

  int checks = 0;
  int errors = 0;

`ifdef BUS_SEQ_PIPELINE_EN
  localparam int PER = 4;
  localparam int DONE_P = 0;
`else
  localparam int PER = 5;
  localparam int DONE_P = 4;
`endif

  bus_cycle_seq #(.ADDR_W(16), .IDLE_DATA(8'hFF)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_rd(req_rd), .req_wr(req_wr),
    .req_addr(req_addr), .wdata(wdata),
    .WAIT(WAIT), .Test1(Test1), .DL(DL),
    .A(A), .RD(RD), .WR(WR), .DataOut(DataOut),
    .DV(DV), .rdata(rdata), .ready(ready),
    .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    req_rd = 0; req_wr = 0; req_addr = '0;
    wdata = '0; WAIT = 0; Test1 = 0; DL = '0;
    #12;
    RESET = 1'b0;
    step();
    checks++;
    if ({RD, WR, DataOut, done, err, ready} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_strobes got %b exp 000001",
               {RD, WR, DataOut, done, err, ready});
    end
    checks++;
    if ({A, DV, rdata} !== {16'h0000, 8'h00, 8'hFF}) begin
      errors++;
      $display("FAIL reset_regs got %h exp 000000ff",
               {A, DV, rdata});
    end
  endtask

  task automatic test_read();
    req_rd = 1; req_addr = 16'hC000;
    for (int c = 1; c <= 4; c++) begin
      step();
      req_rd = 0; req_addr = 16'h0000;
      if (c == 3) DL = 8'h5A;
      if (c == 4) DL = 8'h00;
      checks++;
      if (RD !== (c <= 3) || done !== (c == 4)) begin
        errors++;
        $display("FAIL read_c%0d got RD=%b done=%b", c, RD, done);
      end
    end
    checks++;
    if (A !== 16'hC000 || rdata !== 8'h5A) begin
      errors++;
      $display("FAIL read_data got A=%h rdata=%h exp C000 5a",
               A, rdata);
    end
    step();
    checks++;
    if (ready !== 1 || done !== 0) begin
      errors++;
      $display("FAIL read_idle got ready=%b done=%b exp 1 0",
               ready, done);
    end
  endtask

  task automatic test_write();
    req_wr = 1; req_addr = 16'h8001; wdata = 8'h3C;
    for (int c = 1; c <= 4; c++) begin
      step();
      req_wr = 0; wdata = 8'h00;
      checks++;
      if (WR !== (c == 2 || c == 3) || DataOut !== (c == 2 || c == 3) ||
          RD !== 0 || done !== (c == 4)) begin
        errors++;
        $display("FAIL write_c%0d got RD=%b WR=%b DO=%b done=%b",
                 c, RD, WR, DataOut, done);
      end
    end
    checks++;
    if (DV !== 8'h3C || A !== 16'h8001 || rdata !== 8'h5A) begin
      errors++;
      $display("FAIL write_hold got DV=%h A=%h rdata=%h exp 3c 8001 5a",
               DV, A, rdata);
    end
    step();
  endtask

  task automatic test_wait();
    req_rd = 1; req_addr = 16'h1234;
    for (int c = 1; c <= 7; c++) begin
      step();
      req_rd = 0;
      WAIT = (c >= 2 && c <= 4);
      DL = (c == 6) ? 8'hA7 : 8'h00;
      checks++;
      if (RD !== (c <= 6) || done !== (c == 7)) begin
        errors++;
        $display("FAIL wait_c%0d got RD=%b done=%b", c, RD, done);
      end
      if (c == 6) begin
        checks++;
        if (rdata !== 8'h5A) begin
          errors++;
          $display("FAIL wait_early got %h exp 5a", rdata);
        end
      end
    end
    checks++;
    if (rdata !== 8'hA7) begin
      errors++;
      $display("FAIL wait_rdata got %h exp a7", rdata);
    end
    step();
  endtask

  task automatic test_illegal();
    req_rd = 1; req_wr = 1; req_addr = 16'hBEEF; wdata = 8'h77;
    step();
    req_rd = 0; req_wr = 0;
    checks++;
    if (err !== 1 || ready !== 1 || RD !== 0 || WR !== 0) begin
      errors++;
      $display("FAIL illegal_pulse got err=%b ready=%b RD=%b WR=%b",
               err, ready, RD, WR);
    end
    step();
    checks++;
    if (err !== 0 || A !== 16'h1234 || DV !== 8'h3C) begin
      errors++;
      $display("FAIL illegal_after got err=%b A=%h DV=%h exp 0 1234 3c",
               err, A, DV);
    end
  endtask

  task automatic test_test1();
    Test1 = 1; req_rd = 1; req_addr = 16'h4000; DL = 8'h99;
    for (int c = 1; c <= 4; c++) begin
      step();
      req_rd = 0;
      checks++;
      if (RD !== 0 || done !== (c == 4)) begin
        errors++;
        $display("FAIL test1_c%0d got RD=%b done=%b", c, RD, done);
      end
      if (c == 2) begin
        Test1 = 0;
        #1;
        checks++;
        if (RD !== 1) begin
          errors++;
          $display("FAIL test1_unmask got RD=%b exp 1", RD);
        end
        Test1 = 1;
        #1;
      end
    end
    checks++;
    if (rdata !== 8'hFF) begin
      errors++;
      $display("FAIL test1_rdata got %h exp ff", rdata);
    end
    Test1 = 0;
    step();
  endtask

  task automatic test_reset_mid();
    req_wr = 1; req_addr = 16'h2222; wdata = 8'h11;
    step();
    req_wr = 0;
    step();
    checks++;
    if (WR !== 1 || DataOut !== 1) begin
      errors++;
      $display("FAIL rstmid_t2 got WR=%b DO=%b exp 1 1", WR, DataOut);
    end
    RESET = 1;
    #1;
    checks++;
    if (WR !== 0 || DataOut !== 0 || ready !== 1 || rdata !== 8'hFF ||
        A !== 16'h0000 || DV !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_drop got WR=%b DO=%b rdy=%b rd=%h A=%h DV=%h",
               WR, DataOut, ready, rdata, A, DV);
    end
    #3;
    RESET = 0;
    for (int c = 1; c <= 4; c++) begin
      step();
      checks++;
      if (done !== 0 || ready !== 1) begin
        errors++;
        $display("FAIL rstmid_c%0d got done=%b ready=%b exp 0 1",
                 c, done, ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    int p;
    req_rd = 1; req_addr = 16'h5555;
    for (int c = 1; c <= 13; c++) begin
      step();
      p = c % PER;
      checks++;
      if (RD !== (p >= 1 && p <= 3) || done !== (p == DONE_P) ||
          ready !== (p == 0)) begin
        errors++;
        $display("FAIL b2b_c%0d got RD=%b done=%b ready=%b",
                 c, RD, done, ready);
      end
    end
    req_rd = 0;
    for (int c = 0; c < 6; c++) step();
    checks++;
    if (ready !== 1 || RD !== 0) begin
      errors++;
      $display("FAIL b2b_drain got ready=%b RD=%b exp 1 0", ready, RD);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_wait();
    test_illegal();
    test_test1();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_cycle_seq.md
Name: bus_cycle_seq

Overview:
- M-cycle bus sequencer for the sm83 core.
- Sits directly upstream of the per-bit data mux.
  - Turns single-cycle read/write requests from the decoder into a T1..T4 bus cycle.
  - Produces the RD/WR strobes, the DataOut enable and the DV write-data operand consumed by the mux.
  - Captures read data from the internal DL bus into a holding register for the decoder and ALU.
- Handles wait-state stretching and the external bus-disable (Test1) condition.

Parameters:
- ADDR_W, 16, address width.
- IDLE_DATA, 8'hFF, value returned on a read aborted by Test1 (the precharged-bus value).

Ports:
- CLK  input  1  core clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- req_rd  input  1  read request; sampled only when ready=1.
- req_wr  input  1  write request; sampled only when ready=1.
- req_addr  input  ADDR_W  address, latched at accept.
- wdata  input  8  write data, latched at accept.
- WAIT  input  1  sampled at the end of T2; 1 inserts a TW state.
- Test1  input  1  bus disable; 1 suppresses RD/WR.
- DL  input  8  internal databus value, sampled at the end of T3/TW.
- A  output  ADDR_W  bus address.
- RD  output  1  read strobe to the data mux.
- WR  output  1  write strobe to the data mux.
- DataOut  output  1  DV -> DL enable to the data mux.
- DV  output  8  write operand to the data mux.
- rdata  output  8  captured read data.
- ready  output  1  sequencer can accept a request this cycle.
- done  output  1  one-cycle pulse in T4.
- err  output  1  one-cycle pulse on an illegal request (rd and wr both set).

Behaviour:
- States: IDLE, T1, T2, TW, T3, T4. Encoded state plus a 1-bit op register (0 = read, 1 = write).
- Reset (asynchronous):
  - state = IDLE.
  - A = 0, DV = 0, rdata = IDLE_DATA.
  - RD = WR = DataOut = done = err = 0, ready = 1.
- IDLE:
  - ready = 1.
  - At an edge with exactly one of req_rd/req_wr = 1: latch req_addr -> A, wdata -> DV (write only), set op, go to T1.
  - Both requests = 1: stay in IDLE, err = 1 for the next cycle, nothing latched.
  - Neither request: stay in IDLE.
- T1:
  - Address stable.
  - Read: RD = 1 from T1.
  - Write: RD = WR = 0.
  - Next state: T2.
- T2:
  - Read: RD = 1.
  - Write: WR = 1 and DataOut = 1 from T2.
  - WAIT = 1 at the edge: go to TW. Otherwise go to T3.
- TW:
  - Same strobes as T2.
  - Remains in TW while WAIT = 1; goes to T3 on the first edge with WAIT = 0.
  - Unbounded; only RESET breaks it.
- T3:
  - Same strobes as T2.
  - At the edge leaving T3, a read loads DL into rdata.
  - Next state: T4.
- T4:
  - RD = WR = DataOut = 0.
  - done = 1.
  - Next state: IDLE.
- Output timing: RD, WR and DataOut are registered outputs decoded from the next state, so they change exactly at T-state boundaries with no glitches.
- Test1:
  - While Test1 = 1, RD and WR are forced to 0 combinationally. DataOut is unaffected.
  - If Test1 = 1 at the T3 exit edge of a read, rdata loads IDLE_DATA instead of DL.
  - The sequence timing is unchanged; done still pulses.
- Latency, no waits:
  - Accept edge -> T1 -> T2 -> T3 -> T4: 4 cycles.
  - done is in the 4th cycle after accept.
  - Back-to-back throughput: one transaction per 5 cycles (one IDLE cycle between transactions).
- Holding rules:
  - A, DV and op stay constant from accept until the next accept.
  - rdata holds until the next completed read.
  - Requests arriving while ready = 0 are ignored; the requester holds them until ready.
- RESET asserted mid-transaction: immediate return to reset values, strobes drop asynchronously. No done pulse is produced.

Optional Feature:
- Macro: BUS_SEQ_PIPELINE_EN.
- Defined:
  - ready = 1 in T4 as well as in IDLE.
  - A valid request sampled at the T4 edge goes straight to T1; done still pulses for the finished transaction.
  - Throughput becomes one transaction per 4 cycles.
  - An illegal request in T4 goes to IDLE with err = 1.
- Undefined: ready = 1 only in IDLE, as above.

Test Plan:
- Read: req_rd = 1, req_addr = 16'hC000, DL = 8'h5A in T3 -> A = C000 from T1; RD = 1 in T1..T3; rdata = 5A in T4; done = 1 in cycle 4 only.
- Write: req_wr = 1, wdata = 8'h3C -> DV = 3C from T1; WR = DataOut = 1 in T2..T3 only; done in cycle 4; rdata unchanged.
- Wait states: read with WAIT = 1 for 3 cycles at T2 -> three TW cycles with RD = 1; rdata captured after TW; done in cycle 7.
- Illegal request and Test1: req_rd = req_wr = 1 -> err pulses once, state stays IDLE. Read with Test1 = 1 -> RD = 0 throughout, rdata = FF, done pulses.
- Reset mid-cycle: RESET pulsed during T2 of a write -> WR and DataOut drop immediately; ready = 1, rdata = FF after release.
- Back-to-back (both builds): requests held continuously -> accepts every 5 cycles without BUS_SEQ_PIPELINE_EN; every 4 cycles with BUS_SEQ_PIPELINE_EN, with no IDLE cycle between.
